// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter slice: direction encodings and
// the per-edge next-state selection enum with its priority resolver.
package counter_pkg;

  // Encoding of the 'up' input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Source of the next count value, in decreasing priority.
  typedef enum logic [1:0] {
    NS_CLEAR,
    NS_LOAD,
    NS_COUNT,
    NS_HOLD
  } ns_sel_e;

  // Resolve the control inputs into a single selection: clear > load > en > hold.
  function automatic ns_sel_e ns_select(input logic clear, input logic load,
                                        input logic en);
    ns_sel_e sel;
    if (clear) begin
      sel = NS_CLEAR;
    end else if (load) begin
      sel = NS_LOAD;
    end else if (en) begin
      sel = NS_COUNT;
    end else begin
      sel = NS_HOLD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-value logic for sync_updown_counter.
// Produces the counted value (increment/decrement with modulus wrap), the
// clamped parallel-load value, the terminal-count flag and a wrap detect.
// Build option: define COUNTER_SAT_EN to hold at the terminal value instead
// of wrapping; wrap_o then never asserts.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_next_o,
  output logic [WIDTH-1:0] load_next_o,
  output logic             tc_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic at_top;
  logic at_bot;

  assign at_top = (cnt_i == MAX_VAL);
  assign at_bot = (cnt_i == '0);

  // Terminal count is purely combinational on the current state and controls.
  always_comb begin
    tc_o = en_i & (((up_i == DIR_UP) & at_top) | ((up_i == DIR_DOWN) & at_bot));
  end

  // Value the register takes on a counting edge, and whether that edge wraps.
  always_comb begin
    cnt_next_o = cnt_i;
    wrap_o     = 1'b0;
    if (up_i == DIR_UP) begin
      if (at_top) begin
`ifdef COUNTER_SAT_EN
        cnt_next_o = cnt_i;
`else
        cnt_next_o = '0;
        wrap_o     = 1'b1;
`endif
      end else begin
        cnt_next_o = cnt_i + WIDTH'(1);
      end
    end else begin
      if (at_bot) begin
`ifdef COUNTER_SAT_EN
        cnt_next_o = cnt_i;
`else
        cnt_next_o = MAX_VAL;
        wrap_o     = 1'b1;
`endif
      end else begin
        cnt_next_o = cnt_i - WIDTH'(1);
      end
    end
  end

  // Out-of-range load values are clamped to the top of the count range.
  always_comb begin
    if (64'(load_val_i) >= MODULUS) begin
      load_next_o = MAX_VAL;
    end else begin
      load_next_o = load_val_i;
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-N up/down counter with clear, parallel load, terminal
// count and a registered wrap pulse. Asynchronous active-high reset.
// Build option: define COUNTER_SAT_EN for saturating (non-wrapping) mode.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_updown_counter: WIDTH must be within 1..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS must be within 2..2**WIDTH");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] load_next;
  logic             cnt_wraps;
  ns_sel_e          sel;

  counter_next_val #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next_val (
    .cnt_i       (count_q),
    .en_i        (en),
    .up_i        (up),
    .load_val_i  (load_val),
    .cnt_next_o  (cnt_next),
    .load_next_o (load_next),
    .tc_o        (tc),
    .wrap_o      (cnt_wraps)
  );

  // Pick the next-state source by priority and derive the wrap pulse from it.
  always_comb begin
    sel     = ns_select(clear, load, en);
    count_d = count_q;
    wrap_d  = 1'b0;
    case (sel)
      NS_CLEAR: count_d = '0;
      NS_LOAD:  count_d = load_next;
      NS_COUNT: begin
        count_d = cnt_next;
        wrap_d  = cnt_wraps;
      end
      default:  count_d = count_q;
    endcase
  end

  // Count and wrap registers; reset acts immediately, independent of clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign qb   = ~count_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench for sync_updown_counter: a MODULUS=10 and a MODULUS=16
// instance share stimulus; expected outputs come from an independent model.
module tb_sync_updown_counter;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up;
  logic [3:0] q10, qb10, q16, qb16;
  logic       tc10, wrap10, tc16, wrap16;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int q10;
    int w10;
    int q16;
    int w16;
  } exp_t;

  exp_t sb[$];
  int   m10;
  int   m16;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clock(clock), .reset(reset), .clear(clear), .load(load),
    .load_val(load_val), .en(en), .up(up),
    .q(q10), .qb(qb10), .tc(tc10), .wrap(wrap10)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clock(clock), .reset(reset), .clear(clear), .load(load),
    .load_val(load_val), .en(en), .up(up),
    .q(q16), .qb(qb16), .tc(tc16), .wrap(wrap16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_tc(input int cq, input int md, input logic e, input logic u);
    return (e && ((u && cq == md - 1) || (!u && cq == 0))) ? 1 : 0;
  endfunction

  task automatic model_next(input int cq, input int md, input logic c, input logic l,
                            input int lv, input logic e, input logic u,
                            output int nq, output int nw);
    nq = cq;
    nw = 0;
    if (c) begin
      nq = 0;
    end else if (l) begin
      nq = (lv >= md) ? md - 1 : lv;
    end else if (e) begin
      if (u) begin
        if (cq == md - 1) begin
`ifdef COUNTER_SAT_EN
          nq = cq;
`else
          nq = 0;
          nw = 1;
`endif
        end else begin
          nq = cq + 1;
        end
      end else begin
        if (cq == 0) begin
`ifdef COUNTER_SAT_EN
          nq = cq;
`else
          nq = md - 1;
          nw = 1;
`endif
        end else begin
          nq = cq - 1;
        end
      end
    end
  endtask

  task automatic compare_out();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("q10", 32'(q10), x.q10);
      chk("qb10", 32'(qb10), (~x.q10) & 15);
      chk("wrap10", 32'(wrap10), x.w10);
      chk("q16", 32'(q16), x.q16);
      chk("qb16", 32'(qb16), (~x.q16) & 15);
      chk("wrap16", 32'(wrap16), x.w16);
      m10 = x.q10;
      m16 = x.q16;
    end
  endtask

  // Drive one cycle of stimulus, check tc combinationally, then check the edge result.
  task automatic step(input logic c, input logic l, input int lv, input logic e, input logic u);
    exp_t x;
    clear    = c;
    load     = l;
    load_val = 4'(lv);
    en       = e;
    up       = u;
    #1;
    chk("tc10", 32'(tc10), model_tc(m10, 10, e, u));
    chk("tc16", 32'(tc16), model_tc(m16, 16, e, u));
    model_next(m10, 10, c, l, lv, e, u, x.q10, x.w10);
    model_next(m16, 16, c, l, lv, e, u, x.q16, x.w16);
    sb.push_back(x);
    @(posedge clock);
    #1;
    compare_out();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_q10"}, 32'(q10), 0);
    chk({tag, "_qb10"}, 32'(qb10), 15);
    chk({tag, "_wrap10"}, 32'(wrap10), 0);
    chk({tag, "_q16"}, 32'(q16), 0);
    chk({tag, "_qb16"}, 32'(qb16), 15);
    chk({tag, "_wrap16"}, 32'(wrap16), 0);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state(tag);
    @(negedge clock);
    check_reset_state({tag, "_held"});
    reset = 1'b0;
    m10 = 0;
    m16 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    load = 1'b0;
    load_val = '0;
    en = 1'b0;
    up = 1'b1;
    m10 = 0;
    m16 = 0;
    #3;
    check_reset_state("rst");
    en = 1'b1;
    up = 1'b0;
    #1;
    chk("rst_tc10_down", 32'(tc10), model_tc(0, 10, 1'b1, 1'b0));
    chk("rst_tc16_down", 32'(tc16), model_tc(0, 16, 1'b1, 1'b0));
    up = 1'b1;
    #1;
    chk("rst_tc10_up", 32'(tc10), model_tc(0, 10, 1'b1, 1'b1));
    @(posedge clock);
    #1;
    check_reset_state("rst_edge");
    @(negedge clock);
    reset = 1'b0;

    // Up-count 12 edges from reset.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b1);

    // Down from 0, then toggle direction on consecutive edges at the extremes.
    step(1'b1, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);

    // Priority and load clamping.
    step(1'b1, 1'b1, 5, 1'b1, 1'b1);
    step(1'b0, 1'b1, 12, 1'b1, 1'b1);
    step(1'b0, 1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 1'b1, 15, 1'b1, 1'b0);
    step(1'b0, 1'b1, 9, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b0, i[0]);

    // Asynchronous reset mid-count at 7, then with a wrap pulse pending.
    step(1'b0, 1'b1, 6, 1'b0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 1'b1);
    async_reset_pulse("arst_q7");
    step(1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8, 1'b0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 1'b1);
    async_reset_pulse("arst_wrap");

    // Long runs to the extremes in both directions.
    step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Random mix of controls.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(7) == 0) ? 1'b1 : 1'b0,
           int'($urandom_range(15)),
           ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
           1'($urandom_range(1)));
    end

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
